muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
- Consumes the two register read operands and produces a result plus a write-back request (register index, write enable) for the register-file write port.
- Holds a busy signal so the control unit stalls while an operation runs.
- Instruction decode supplies funct3; this block never decodes opcodes.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_divcore.sv | 27 ++
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared encodings for the RV32M multiply/divide unit.
//   FUNCT3_*  : RV32M operation encodings as delivered by instruction decode.
//   state_e   : FSM encoding (ST_IDLE, ST_CALC, ST_DONE).
//   cond_neg  : two's-complement negate when the flag is set (sign fix-up).
package muldiv_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_divcore.sv
// muldiv_divcore -- one combinational restoring-division step.
//   rem          : partial remainder before this step
//   dividend_bit : next dividend bit, MSB first
//   divisor      : divisor magnitude
//   rem_next     : partial remainder after this step
//   q_bit        : quotient bit produced by this step
module muldiv_divcore #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0] shifted;

    always_comb begin
        shifted  = {rem, dividend_bit};
        q_bit    = (shifted >= {1'b0, divisor});
        // When the subtract is taken the difference is below the divisor, so
        // the top bit of the shifted remainder always drops out.
        rem_next = shifted[XLEN-1:0] - (q_bit ? divisor : '0);
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit feeding the register-file
// write port.
//   iCLK, iRST           : clock, asynchronous active-high reset
//   iStart, iFlush       : start request (taken in IDLE only), synchronous abort
//   iFunct3              : RV32M operation select
//   iRs1Data, iRs2Data   : operands, captured on acceptance
//   iRd                  : destination register index
//   oBusy                : operation in flight, control stalls on it
//   oDone                : one-cycle result strobe
//   oResult              : write data (holds after oDone)
//   oWriteRegister       : write index (holds after oDone)
//   oRegWrite            : write enable, oDone with rd != 0
// Build option MULDIV_FAST_MUL_EN: multiplies use one 33x33 signed multiplier
// and skip the iterative phase; divides are unaffected.
// Outputs are registered from the DONE cycle, so oDone appears one edge after
// the FSM reaches DONE (34th edge counting the accepting edge as the first).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iStart,
    input  logic            iFlush,
    input  logic [2:0]      iFunct3,
    input  logic [XLEN-1:0] iRs1Data,
    input  logic [XLEN-1:0] iRs2Data,
    input  logic [4:0]      iRd,
    output logic            oBusy,
    output logic            oDone,
    output logic [XLEN-1:0] oResult,
    output logic [4:0]      oWriteRegister,
    output logic            oRegWrite
);

    state_e            state, nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3;
    logic [4:0]        rd;
    logic              a_neg, res_neg, bypass;
    logic [XLEN-1:0]   byp_res;
    // mul: opa = multiplicand shifting left, opb = multiplier shifting right,
    //      acc = 64-bit magnitude product.
    // div: opa[XLEN-1:0] = dividend shifting out / quotient shifting in,
    //      opb = divisor, acc[XLEN-1:0] = partial remainder.
    logic [2*XLEN-1:0] opa, acc;
    logic [XLEN-1:0]   opb;

    // Acceptance decode on the raw register-file operands
    logic            accept, sgn_a, sgn_b, in_a_neg, in_b_neg;
    logic            div_zero, div_ovf, fast_mul, go_short;
    logic [XLEN-1:0] byp_d;

    always_comb begin
        accept   = (state == ST_IDLE) && iStart && !iFlush && !oBusy;
        sgn_a    = (iFunct3 != FUNCT3_MULHU) && (iFunct3 != FUNCT3_DIVU) && (iFunct3 != FUNCT3_REMU);
        sgn_b    = sgn_a && (iFunct3 != FUNCT3_MULHSU);
        in_a_neg = sgn_a && iRs1Data[XLEN-1];
        in_b_neg = sgn_b && iRs2Data[XLEN-1];
        div_zero = iFunct3[2] && (iRs2Data == '0);
        div_ovf  = ((iFunct3 == FUNCT3_DIV) || (iFunct3 == FUNCT3_REM)) &&
                   (iRs1Data == {1'b1, {(XLEN-1){1'b0}}}) && (iRs2Data == '1);
        // Overflow DIV returns rs1 itself (the most negative value).
        if (iFunct3[1]) byp_d = div_zero ? iRs1Data : '0;
        else            byp_d = div_zero ? '1 : iRs1Data;
`ifdef MULDIV_FAST_MUL_EN
        fast_mul = !iFunct3[2];
`else
        fast_mul = 1'b0;
`endif
        go_short = div_zero || div_ovf || fast_mul;
    end

    logic [XLEN-1:0] dc_rem;
    logic            dc_q;

    muldiv_divcore #(.XLEN(XLEN)) u_divcore (
        .rem          (acc[XLEN-1:0]),
        .dividend_bit (opa[XLEN-1]),
        .divisor      (opb),
        .rem_next     (dc_rem),
        .q_bit        (dc_q)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0] fa, fb;
`endif

    // State register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= ST_IDLE;
        else      state <= nxt;
    end

    // Next state
    always_comb begin
        nxt = state;
        if (iFlush) nxt = ST_IDLE;
        else begin
            case (state)
                ST_IDLE: if (accept) nxt = go_short ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt == CNT_W'(XLEN-1)) nxt = ST_DONE;
                ST_DONE: nxt = ST_IDLE;
                default: nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt <= '0; f3 <= '0; rd <= '0; a_neg <= 1'b0; res_neg <= 1'b0;
            bypass <= 1'b0; byp_res <= '0; opa <= '0; opb <= '0; acc <= '0;
`ifdef MULDIV_FAST_MUL_EN
            fa <= '0; fb <= '0;
`endif
        end else if (accept) begin
            cnt     <= '0;
            f3      <= iFunct3;
            rd      <= iRd;
            a_neg   <= in_a_neg;
            res_neg <= in_a_neg ^ in_b_neg;
            bypass  <= div_zero || div_ovf;
            byp_res <= byp_d;
            opa     <= {{XLEN{1'b0}}, cond_neg(in_a_neg, iRs1Data)};
            opb     <= cond_neg(in_b_neg, iRs2Data);
            acc     <= '0;
`ifdef MULDIV_FAST_MUL_EN
            fa <= {sgn_a && iRs1Data[XLEN-1], iRs1Data};
            fb <= {sgn_b && iRs2Data[XLEN-1], iRs2Data};
`endif
        end else if (state == ST_CALC) begin
            cnt <= cnt + 1'b1;
            if (f3[2]) begin
                acc <= {{XLEN{1'b0}}, dc_rem};
                opa <= {{XLEN{1'b0}}, opa[XLEN-2:0], dc_q};
            end else begin
                if (opb[0]) acc <= acc + opa;
                opa <= opa << 1;
                opb <= opb >> 1;
            end
        end
    end

    // Output logic: sign fix-up and result select in DONE
    logic [2*XLEN-1:0] mp;
    logic [XLEN-1:0]   res;
    logic              done_d, busy_d, regwr_d;

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        mp = $signed({{(XLEN-1){fa[XLEN]}}, fa}) * $signed({{(XLEN-1){fb[XLEN]}}, fb});
`else
        mp = res_neg ? -acc : acc;
`endif
        if (bypass)       res = byp_res;
        else if (f3[2])   res = f3[1] ? cond_neg(a_neg, acc[XLEN-1:0]) : cond_neg(res_neg, opa[XLEN-1:0]);
        else if (f3 == FUNCT3_MUL) res = mp[XLEN-1:0];
        else              res = mp[2*XLEN-1:XLEN];
        done_d  = (state == ST_DONE) && !iFlush;
        // Busy also covers the registered result cycle after DONE.
        busy_d  = !iFlush && ((nxt != ST_IDLE) || (state == ST_DONE));
        regwr_d = done_d && (rd != 5'd0);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDone <= 1'b0; oBusy <= 1'b0; oRegWrite <= 1'b0;
            oResult <= '0; oWriteRegister <= '0;
        end else begin
            oDone     <= done_d;
            oBusy     <= busy_d;
            oRegWrite <= regwr_d;
            if (done_d) begin
                oResult        <= res;
                oWriteRegister <= rd;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- self-checking bench for muldiv_unit: directed cases,
// randomized operations against an arithmetic reference, flush, ignored start,
// and asynchronous reset. Honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;

    logic        iCLK = 1'b0;
    logic        iRST, iStart, iFlush;
    logic [2:0]  iFunct3;
    logic [31:0] iRs1Data, iRs2Data;
    logic [4:0]  iRd;
    logic        oBusy, oDone, oRegWrite;
    logic [31:0] oResult;
    logic [4:0]  oWriteRegister;

    int tests = 0;
    int fails = 0;

    muldiv_unit dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iFlush(iFlush),
        .iFunct3(iFunct3), .iRs1Data(iRs1Data), .iRs2Data(iRs2Data), .iRd(iRd),
        .oBusy(oBusy), .oDone(oDone), .oResult(oResult),
        .oWriteRegister(oWriteRegister), .oRegWrite(oRegWrite)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RV32M semantics with plain integer arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
            3'd2: begin sp = longint'($signed(a)) * longint'({32'd0, b}); return sp[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return a; return sa / sb; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; if (ovf) return 32'd0; return sa % sb; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    // Edges after the accepting edge until oDone is seen. The accepting edge
    // is itself the first of the 34, so iterative ops show oDone 33 edges later.
    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`else
            return 33;
`endif
        end
        if (b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input string tag);
        logic [31:0] exp_r;
        int          exp_l, n;
        exp_r = ref_res(f3, a, b);
        exp_l = ref_lat(f3, a, b);
        @(negedge iCLK);
        iStart = 1'b1; iFunct3 = f3; iRs1Data = a; iRs2Data = b; iRd = rd;
        @(posedge iCLK); #1;
        // Scramble inputs: the unit must work from captured operands.
        iStart = 1'b0; iRs1Data = $urandom; iRs2Data = $urandom;
        iFunct3 = 3'($urandom); iRd = 5'($urandom);
        n = 0;
        do begin
            @(posedge iCLK); #1;
            n++;
            if (n == 1) chk({tag, ".busy1"}, oBusy, 1);
        end while (!oDone && n < 100);
        chk({tag, ".lat"},  n, exp_l);
        chk({tag, ".res"},  oResult, exp_r);
        chk({tag, ".wreg"}, oWriteRegister, rd);
        chk({tag, ".rw"},   oRegWrite, (rd != 0));
        chk({tag, ".busyd"}, oBusy, 1);
        @(posedge iCLK); #1;
        chk({tag, ".done0"}, oDone, 0);
        chk({tag, ".busy0"}, oBusy, 0);
        chk({tag, ".hold"},  oResult, exp_r);
    endtask

    initial begin
        int n, dones;
        iRST = 1'b1; iStart = 1'b0; iFlush = 1'b0; iFunct3 = '0;
        iRs1Data = '0; iRs2Data = '0; iRd = '0;
        repeat (2) @(posedge iCLK);
        #1;
        chk("rst.busy", oBusy, 0);
        chk("rst.done", oDone, 0);
        chk("rst.res",  oResult, 0);
        chk("rst.wreg", oWriteRegister, 0);
        chk("rst.rw",   oRegWrite, 0);
        @(negedge iCLK); iRST = 1'b0;

        // Directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhsu");
        run_op(3'd4, -32'sd20, 32'd3, 5'd3, "div");
        run_op(3'd6, -32'sd20, 32'd3, 5'd4, "rem");
        run_op(3'd5, 32'd123, 32'd0, 5'd6, "divu0");
        run_op(3'd7, 32'd123, 32'd0, 5'd6, "remu0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, "divovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, "removf");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, "divovf_rd0");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd9, "mulh_min");

        // iStart held while busy is ignored and not queued
        @(negedge iCLK);
        iStart = 1'b1; iFunct3 = 3'd5; iRs1Data = 32'd100; iRs2Data = 32'd7; iRd = 5'd3;
        @(posedge iCLK); #1;
        iFunct3 = 3'd0; iRs1Data = 32'd5; iRs2Data = 32'd5;
        n = 0;
        do begin
            @(posedge iCLK); #1;
            n++;
            if (n == 5) iStart = 1'b0;
        end while (!oDone && n < 100);
        chk("ign.lat", n, 33);
        chk("ign.res", oResult, 32'd14);
        dones = 0;
        repeat (40) begin @(posedge iCLK); #1; if (oDone) dones++; end
        chk("ign.noqueue", dones, 0);

        // Flush ten cycles into CALC, then a new start right away
        @(negedge iCLK);
        iStart = 1'b1; iFunct3 = 3'd4; iRs1Data = -32'sd1000; iRs2Data = 32'd7; iRd = 5'd9;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        repeat (9) @(posedge iCLK);
        @(negedge iCLK); iFlush = 1'b1;
        @(posedge iCLK); #1;
        iFlush = 1'b0;
        chk("flush.busy", oBusy, 0);
        chk("flush.done", oDone, 0);
        chk("flush.rw",   oRegWrite, 0);
        run_op(3'd4, 32'd999, 32'd10, 5'd11, "postflush");

        // Flush and start together in IDLE: nothing accepted
        @(negedge iCLK);
        iFlush = 1'b1; iStart = 1'b1; iFunct3 = 3'd4; iRs1Data = 32'd50; iRs2Data = 32'd5; iRd = 5'd2;
        @(posedge iCLK); #1;
        iFlush = 1'b0; iStart = 1'b0;
        chk("fs.busy", oBusy, 0);
        dones = 0;
        repeat (40) begin @(posedge iCLK); #1; if (oDone) dones++; end
        chk("fs.nodone", dones, 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), pick(), pick(), 5'($urandom), $sformatf("rnd%0d", i));
        end

        // Asynchronous reset mid-CALC, checked before any clock edge
        @(negedge iCLK);
        iStart = 1'b1; iFunct3 = 3'd5; iRs1Data = 32'd77; iRs2Data = 32'd5; iRd = 5'd12;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        repeat (5) @(posedge iCLK);
        @(negedge iCLK); #2;
        iRST = 1'b1;
        #1;
        chk("arst.busy", oBusy, 0);
        chk("arst.done", oDone, 0);
        chk("arst.res",  oResult, 0);
        chk("arst.wreg", oWriteRegister, 0);
        chk("arst.rw",   oRegWrite, 0);
        @(negedge iCLK); iRST = 1'b0;
        run_op(3'd7, 32'd77, 32'd5, 5'd12, "postrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
